dnn_stream_mover: RTL
=====================

# dnn_stream_mover

Host-side stream mover that drives the accelerator's `src` stream and absorbs its `dst` stream. Transmitter reads `src_len` words from local memory and sends them with `src_last` on the final beat. Receiver accepts `dst_len` words and writes them back to memory. It is the peer of the accelerator top-level stream ports, replacing the external DMA in block-level and system simulations.

## Interface
Parameters:
- `AW`, 16: memory word-address width.
- `LW`, 12: transfer length width, counted in beats.

Ports:
- `clk` in 1: sole clock.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that launches both directions. Ignored while `busy`.
- `src_base` in AW: first read address. Sampled on `start`.
- `src_len` in LW: beats to transmit. Sampled on `start`.
- `dst_base` in AW: first write address. Sampled on `start`.
- `dst_len` in LW: beats to receive. Sampled on `start`.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse when both directions are complete.
- `err` out 1: sticky `dst_last` mismatch flag. Cleared on `start`.
- `mem_ren` out 1 / `mem_raddr` out AW: read port. `mem_rdata` in 32 returns exactly 1 cycle after `mem_ren`.
- `mem_wen` out 1 / `mem_waddr` out AW / `mem_wdata` out 32: write port. Write takes effect in the same cycle.
- `src_valid` out 1, `src_data` out 32, `src_last` out 1, `src_ready` in 1: transmit stream.
- `dst_valid` in 1, `dst_data` in 32, `dst_last` in 1, `dst_ready` out 1: receive stream.

## Operation
- A beat transfers when valid and ready are both high on a rising edge.
- TX FSM states: `TX_IDLE`, `TX_RUN`, `TX_DRAIN`.
  - `start` moves the FSM to `TX_RUN`, or directly to tx-complete if `src_len`=0.
  - In `TX_RUN`, a read is issued when the skid FIFO will have room counting reads in flight. The rule is: issue iff occupancy + inflight < 2.
  - Returned data is pushed into the FIFO.
  - After the last read is issued, the FSM enters `TX_DRAIN`. It goes to `TX_IDLE` when the FIFO is empty and the final beat has been accepted.
- `src_last` is high only on beat index `src_len`-1. `src_data` comes from the FIFO head, and `src_valid` = FIFO not empty.
- Once high, `src_valid` and `src_data` hold stable until the beat is accepted, independent of memory behaviour.
- RX FSM states: `RX_IDLE`, `RX_RUN`.
  - `dst_ready` is high only in `RX_RUN`.
  - Each accepted beat writes `mem_wdata`=`dst_data` at address `dst_base`+count in the same cycle, then count increments.
  - The FSM exits `RX_RUN` on beat `dst_len`-1, or earlier if `dst_last` arrives. With `dst_len`=0 it completes immediately.
- `err` is set when `dst_last` does not coincide with beat `dst_len`-1, in either direction: early `dst_last`, or final beat without `dst_last`.
- After RX completes, `dst_ready` stays low. Surplus beats are back-pressured, not dropped.
- `done` pulses in the first cycle both directions are idle after a `start`. `busy` falls in the same cycle.
- Address arithmetic is modulo 2^AW and wraps silently. Counts are LW bits, so the maximum transfer is 2^LW-1 beats.
- A reset mid-transfer abandons it: the FIFO is flushed, counters are cleared, and every output goes to its reset value.

## Timing
- Reset values: `busy`, `done`, `err`, `mem_ren`, `mem_wen`, `src_valid`, `src_last`, `dst_ready` = 0. `mem_raddr`, `mem_waddr`, `mem_wdata`, `src_data` = 0.
- `start` at cycle 0:
  - `busy` = 1 and the first `mem_ren` at cycle 1.
  - First `src_valid` at cycle 3 (FIFO registered output).
  - `dst_ready` = 1 at cycle 1.
- With `src_ready` held high the transmitter sustains 1 beat/cycle.
- With `src_ready` toggling, no beat is lost or duplicated. At most 2 words are buffered.
- `done` follows the later of the two completions by 1 cycle.

## Configuration
- `DNN_MOVER_PACK16_EN` defined:
  - Memory holds two bf16 values per word: low half first, then high half.
  - Each read yields two beats, each with `src_data`={value,16'h0}. `src_len` still counts beats, and an odd `src_len` discards the last high half.
  - RX is unchanged.
- Undefined: one memory word per beat, sent unmodified.

## Structure
- Package `dnn_stream_pkg`: tx/rx state enums and `AW`/`LW` default constants.
- Sub-module `stream_fifo2`: 2-entry first-word-fall-through skid FIFO with push/pop, count and flush, used by the TX path.

## Test plan
- `src_len`=4, `src_base`=0x10, memory 0x10..0x13 = A,B,C,D, `src_ready`=1 → beats A,B,C,D on cycles 3–6, `src_last` only with D.
- Same data, `src_ready` pattern 1,0,0,1,0,1,1 → order A,B,C,D preserved, `src_data` stable while stalled, at most 2 reads outstanding.
- `dst_len`=3, `dst_base`=0x40, input X,Y,Z with `dst_last` on Z → memory 0x40..0x42 = X,Y,Z, `err`=0, `done` pulses once.
- `dst_len`=3, `dst_last` on the 2nd beat → 2 writes, `err`=1, `dst_ready`=0 afterwards, `done` still pulses.
- `src_len`=0 and `dst_len`=0 → `done` 2 cycles after `start`, no `mem_ren`, `mem_wen` or `src_valid`. With `DNN_MOVER_PACK16_EN` and word 0x22221111: beats 0x11110000 then 0x22220000.
- `resetn` low for 1 cycle mid-transfer → all outputs at reset values next cycle, and a fresh `start` runs a clean transfer.

Source files
------------

// File: rtl/dnn_stream_pkg.sv
// rtl/dnn_stream_pkg.sv - shared constants and FSM state types for the stream mover
// Contents:
//   DEF_AW / DEF_LW : default memory address width and transfer length width
//   tx_state_e      : transmit FSM states
//   rx_state_e      : receive FSM states
package dnn_stream_pkg;

  localparam int DEF_AW = 16;
  localparam int DEF_LW = 12;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_RUN   = 2'd1,
    TX_DRAIN = 2'd2
  } tx_state_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RUN  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - 2-entry first-word-fall-through skid FIFO with registered head
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   flush_i          : empties the FIFO (contents become don't-care)
//   push_i, data_i   : write one entry; caller never pushes into a full FIFO
//                      unless it pops in the same cycle
//   pop_i            : drop the head entry; caller only pops when count_o != 0
//   data_o           : head entry (valid whenever count_o != 0)
//   count_o          : current occupancy, 0..2
module stream_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;

  assign data_o  = head_q;
  assign count_o = cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else if (flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= data_i;
          else               tail_q <= data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          // Second entry (if any) moves up; a stale tail is harmless when cnt drops to 0.
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dnn_stream_mover.sv
// rtl/dnn_stream_mover.sv - host-side mover: memory -> src stream, dst stream -> memory
// Build option: DNN_MOVER_PACK16_EN - each memory word carries two bf16 values
//   (low half first); every src beat is {value, 16'h0}. RX is unaffected.
// Ports:
//   clk, resetn                       : clock, synchronous active-low reset
//   start                             : launches both directions (ignored while busy)
//   src_base/src_len, dst_base/dst_len: transfer setup, sampled on start
//   busy, done, err                   : status; err is sticky dst_last mismatch
//   mem_ren/mem_raddr/mem_rdata       : read port, data returns one cycle after mem_ren
//   mem_wen/mem_waddr/mem_wdata       : write port, write lands in the same cycle
//   src_valid/src_data/src_last/src_ready : transmit stream
//   dst_valid/dst_data/dst_last/dst_ready : receive stream
module dnn_stream_mover
  import dnn_stream_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int LW = DEF_LW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [LW-1:0] src_len,
  input  logic [AW-1:0] dst_base,
  input  logic [LW-1:0] dst_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_ren,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic          mem_wen,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          src_valid,
  output logic [31:0]   src_data,
  output logic          src_last,
  input  logic          src_ready,
  input  logic          dst_valid,
  input  logic [31:0]   dst_data,
  input  logic          dst_last,
  output logic          dst_ready
);

  localparam logic [AW-1:0] ONE_A = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] ONE_L = {{(LW-1){1'b0}}, 1'b1};

  tx_state_e     tx_state_q;
  rx_state_e     rx_state_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [AW-1:0] raddr_q;
  logic [LW-1:0] rd_left_q;
  logic          rvalid_q;
  logic [LW-1:0] tx_beat_q;
  logic [LW-1:0] src_len_q;
  logic [AW-1:0] wptr_q;
  logic [LW-1:0] rx_cnt_q;
  logic [LW-1:0] dst_len_q;

  logic          start_ok;
  logic          tx_acc;
  logic          rx_acc;
  logic          rx_final;
  logic          fifo_pop;
  logic [1:0]    fifo_cnt;
  logic [31:0]   fifo_head;
  logic [2:0]    occ_after;
  logic          issue;
  logic          tx_drain_done;
  logic [LW-1:0] rd_total_d;

  assign start_ok = start && !busy_q;

  stream_fifo2 #(.W(32)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush_i (start_ok),
    .push_i  (rvalid_q),
    .data_i  (mem_rdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign src_valid = (fifo_cnt != 2'd0);
  assign tx_acc    = src_valid && src_ready;
  assign src_last  = src_valid && (tx_beat_q == src_len_q - ONE_L);

`ifdef DNN_MOVER_PACK16_EN
  // half_q selects which bf16 of the head word is on the stream; the word is
  // retired after its high half, or early when the low half is the final beat.
  logic half_q;

  assign fifo_pop   = tx_acc && (half_q || src_last);
  assign src_data   = half_q ? {fifo_head[31:16], 16'h0000} : {fifo_head[15:0], 16'h0000};
  assign rd_total_d = (src_len >> 1) + {{(LW-1){1'b0}}, src_len[0]};

  always_ff @(posedge clk) begin
    if (!resetn)       half_q <= 1'b0;
    else if (start_ok) half_q <= 1'b0;
    else if (tx_acc)   half_q <= !half_q;
  end
`else
  assign fifo_pop   = tx_acc;
  assign src_data   = fifo_head;
  assign rd_total_d = src_len;
`endif

  // Issue decision sees this cycle's pop, so a streaming consumer keeps the
  // read pipeline full while the FIFO plus the read in flight never exceed 2.
  assign occ_after = {1'b0, fifo_cnt} - {2'b00, fifo_pop} + {2'b00, rvalid_q};
  assign issue     = (tx_state_q == TX_RUN) && (occ_after < 3'd2);

  assign tx_drain_done = !rvalid_q &&
                         ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && fifo_pop));

  assign mem_ren   = issue;
  assign mem_raddr = raddr_q;

  assign dst_ready = (rx_state_q == RX_RUN);
  assign rx_acc    = dst_valid && dst_ready;
  assign rx_final  = (rx_cnt_q == dst_len_q - ONE_L);
  assign mem_wen   = rx_acc;
  assign mem_waddr = wptr_q;
  assign mem_wdata = rx_acc ? dst_data : 32'h0;

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      raddr_q    <= '0;
      rd_left_q  <= '0;
      rvalid_q   <= 1'b0;
      tx_beat_q  <= '0;
      src_len_q  <= '0;
      wptr_q     <= '0;
      rx_cnt_q   <= '0;
      dst_len_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      rvalid_q <= issue;

      if (issue) begin
        raddr_q   <= raddr_q + ONE_A;
        rd_left_q <= rd_left_q - ONE_L;
      end

      if (tx_acc) tx_beat_q <= tx_beat_q + ONE_L;

      case (tx_state_q)
        TX_RUN:   if (issue && (rd_left_q == ONE_L)) tx_state_q <= TX_DRAIN;
        TX_DRAIN: if (tx_drain_done) tx_state_q <= TX_IDLE;
        default:  ;
      endcase

      if (rx_acc) begin
        rx_cnt_q <= rx_cnt_q + ONE_L;
        wptr_q   <= wptr_q + ONE_A;
        // Mismatch in either direction: early dst_last, or final beat without it.
        if (dst_last != rx_final) err_q <= 1'b1;
        if (dst_last || rx_final) rx_state_q <= RX_IDLE;
      end

      if (busy_q && (tx_state_q == TX_IDLE) && (rx_state_q == RX_IDLE)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end

      if (start_ok) begin
        busy_q     <= 1'b1;
        err_q      <= 1'b0;
        src_len_q  <= src_len;
        dst_len_q  <= dst_len;
        raddr_q    <= src_base;
        wptr_q     <= dst_base;
        rd_left_q  <= rd_total_d;
        tx_beat_q  <= '0;
        rx_cnt_q   <= '0;
        tx_state_q <= (src_len == '0) ? TX_IDLE : TX_RUN;
        rx_state_q <= (dst_len == '0) ? RX_IDLE : RX_RUN;
      end
    end
  end

endmodule
